row_col_dec_5x5: RTL

//  Testbench-side monitor for the 5x5 DCO capacitor-array select bus. It samples r_all (zero-active

---
 rtl/row_col_dec_5x5.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/row_col_dec_5x5.sv
// Decodes the 5x5 DCO capacitor-array select bus back to its control word and checks legality.
// Build with ROW_COL_DEC_MINMAX_EN defined to add the word_min/word_max tracking ports.
module row_col_dec_5x5 #(
    parameter int MAX        = 25,
    parameter int ERR_W      = 8,
    parameter int STABLE_CYC = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [4:0]       r_all,
    input  logic [4:0]       row,
    input  logic [4:0]       col,
    output logic [4:0]       word,
    output logic             valid,
    output logic             err,
    output logic             err_sticky,
    output logic [ERR_W-1:0] err_cnt,
    output logic             stable
`ifdef ROW_COL_DEC_MINMAX_EN
    ,
    output logic [4:0]       word_min,
    output logic [4:0]       word_max
`endif
);

    localparam int RC_W = (STABLE_CYC < 2) ? 1 : $clog2(STABLE_CYC + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_TRACK, ST_STABLE} state_t;

    logic [4:0]       s1_r_all_q, s1_r_all_d;
    logic [4:0]       s1_row_q, s1_row_d;
    logic [4:0]       s1_col_q, s1_col_d;
    logic             s1_v_q, s1_v_d;

    logic [4:0]       word_q, word_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic             err_sticky_q, err_sticky_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    state_t           state_q, state_d;
    logic [RC_W-1:0]  run_cnt_q, run_cnt_d;
    logic [4:0]       ref_q, ref_d;

    // Column must be a thermometer filled from bit0 (even rows) or from bit4 (odd rows, snake order).
    logic [5:0] lo_hit;
    logic [5:0] hi_hit;
    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_therm
            localparam logic [4:0] LO_PAT = 5'((1 << gi) - 1);
            localparam logic [4:0] HI_PAT = 5'(~((1 << (5 - gi)) - 1));
            assign lo_hit[gi] = (s1_col_q == LO_PAT);
            assign hi_hit[gi] = (s1_col_q == HI_PAT);
        end
    endgenerate

    logic [2:0] r_val;
    logic       r_ok;
    logic       row_ok;
    logic       col_ok;
    logic [2:0] c_val;
    logic [4:0] sum;
    logic       legal;

    always_comb begin
        r_val = 3'd0;
        r_ok  = 1'b1;
        case (s1_r_all_q[3:0])
            4'b1111: r_val = 3'd0;
            4'b1110: r_val = 3'd1;
            4'b1100: r_val = 3'd2;
            4'b1000: r_val = 3'd3;
            4'b0000: r_val = 3'd4;
            default: r_ok  = 1'b0;
        endcase

        row_ok = (s1_row_q == (5'd1 << r_val));
        col_ok = r_val[0] ? (|hi_hit) : (|lo_hit);

        c_val = 3'd0;
        for (int i = 0; i < 5; i++) begin
            c_val = c_val + 3'(s1_col_q[i]);
        end

        sum   = {r_val, 2'b00} + {2'b00, r_val} + {2'b00, c_val};
        legal = s1_r_all_q[4] && r_ok && row_ok && col_ok
                && !((r_val != 3'd0) && (c_val == 3'd0))
                && ({27'd0, sum} <= 32'(MAX));
    end

    always_comb begin
        s1_r_all_d = en ? r_all : s1_r_all_q;
        s1_row_d   = en ? row   : s1_row_q;
        s1_col_d   = en ? col   : s1_col_q;
        s1_v_d     = en;

        valid_d = s1_v_q & legal;
        err_d   = s1_v_q & ~legal;
        word_d  = valid_d ? sum : word_q;

        // clr dominates a coincident error so software sees a clean slate.
        err_cnt_d    = err_cnt_q;
        err_sticky_d = err_sticky_q;
        if (clr) begin
            err_cnt_d    = '0;
            err_sticky_d = 1'b0;
        end else if (err_d) begin
            err_sticky_d = 1'b1;
            if (err_cnt_q != {ERR_W{1'b1}}) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end
        end
    end

    logic [RC_W-1:0] run_inc;

    always_comb begin
        state_d   = state_q;
        run_cnt_d = run_cnt_q;
        ref_d     = ref_q;
        run_inc   = run_cnt_q + 1'b1;

        if (err_q) begin
            state_d = ST_IDLE;
        end else if (valid_q) begin
            case (state_q)
                ST_IDLE: begin
                    ref_d     = word_q;
                    run_cnt_d = RC_W'(1);
                    state_d   = (STABLE_CYC <= 1) ? ST_STABLE : ST_TRACK;
                end
                ST_TRACK: begin
                    if (word_q == ref_q) begin
                        run_cnt_d = run_inc;
                        if (32'(run_inc) >= 32'(STABLE_CYC)) begin
                            state_d = ST_STABLE;
                        end
                    end else begin
                        ref_d     = word_q;
                        run_cnt_d = RC_W'(1);
                    end
                end
                ST_STABLE: begin
                    if (word_q != ref_q) begin
                        state_d   = ST_TRACK;
                        ref_d     = word_q;
                        run_cnt_d = RC_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_r_all_q   <= '0;
            s1_row_q     <= '0;
            s1_col_q     <= '0;
            s1_v_q       <= 1'b0;
            word_q       <= '0;
            valid_q      <= 1'b0;
            err_q        <= 1'b0;
            err_sticky_q <= 1'b0;
            err_cnt_q    <= '0;
            state_q      <= ST_IDLE;
            run_cnt_q    <= '0;
            ref_q        <= '0;
        end else begin
            s1_r_all_q   <= s1_r_all_d;
            s1_row_q     <= s1_row_d;
            s1_col_q     <= s1_col_d;
            s1_v_q       <= s1_v_d;
            word_q       <= word_d;
            valid_q      <= valid_d;
            err_q        <= err_d;
            err_sticky_q <= err_sticky_d;
            err_cnt_q    <= err_cnt_d;
            state_q      <= state_d;
            run_cnt_q    <= run_cnt_d;
            ref_q        <= ref_d;
        end
    end

    assign word       = word_q;
    assign valid      = valid_q;
    assign err        = err_q;
    assign err_sticky = err_sticky_q;
    assign err_cnt    = err_cnt_q;
    assign stable     = (state_q == ST_STABLE);

`ifdef ROW_COL_DEC_MINMAX_EN
    logic [4:0] word_min_q, word_min_d;
    logic [4:0] word_max_q, word_max_d;

    always_comb begin
        word_min_d = word_min_q;
        word_max_d = word_max_q;
        if (clr) begin
            word_min_d = 5'd31;
            word_max_d = 5'd0;
        end else if (valid_d) begin
            if (sum < word_min_q) word_min_d = sum;
            if (sum > word_max_q) word_max_d = sum;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_min_q <= 5'd31;
            word_max_q <= 5'd0;
        end else begin
            word_min_q <= word_min_d;
            word_max_q <= word_max_d;
        end
    end

    assign word_min = word_min_q;
    assign word_max = word_max_q;
`endif

endmodule
